// File: rtl/hoop_score_tracker.sv
// Hoop scoring stage: synchronise and debounce the break-beam switch, then count baskets into a saturating binary+BCD score while a game runs.
// Optional macro STREAK_BONUS_EN: a basket inside the streak window after the previous one adds 2.
module hoop_score_tracker #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20,
    parameter bit SWITCH_ACT_LOW  = 1'b1,
    parameter int MAX_SCORE       = 99,
    parameter int STREAK_CYCLES   = 100000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       in_switch,
    input  logic       game_start,
    input  logic       game_active,
    output logic [7:0] score,
    output logic [3:0] score_ones,
    output logic [3:0] score_tens,
    output logic       basket_pulse,
    output logic       running,
    output logic       final_valid
);

    // state       | meaning
    // DB_REL      | beam clear and stable
    // DB_CONF_HI  | beam broken, waiting for it to stay broken
    // DB_HELD     | beam broken and accepted (edge already issued)
    // DB_CONF_LO  | beam clear again, waiting for it to stay clear
    // G_IDLE      | no game since reset
    // G_RUN       | scoring window open
    // G_DONE      | game over, score frozen until the next start

    typedef enum logic [1:0] {DB_REL, DB_CONF_HI, DB_HELD, DB_CONF_LO} db_state_t;
    typedef enum logic [1:0] {G_IDLE, G_RUN, G_DONE} game_state_t;

    if ((2 ** CNT_W) <= DEBOUNCE_CYCLES || DEBOUNCE_CYCLES < 1 || MAX_SCORE < 1 ||
        MAX_SCORE > 99 || STREAK_CYCLES < 1) begin : g_param_check
        $error("hoop_score_tracker: parameter set out of range");
    end

    localparam logic             IDLE_LVL = SWITCH_ACT_LOW;
    localparam logic [CNT_W-1:0] DB_LOAD  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0]       SAT      = 8'(MAX_SCORE);

    logic              sync_0, sync_1, hit;
    db_state_t         db_state, db_next;
    logic [CNT_W-1:0]  db_cnt, db_cnt_next;
    logic              edge_set, edge_q;
    game_state_t       game_state, game_next;
    logic              fin_set, count_en, bonus;
    logic [15:0]       step1, step2;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_0 <= IDLE_LVL;
            sync_1 <= IDLE_LVL;
        end else begin
            sync_0 <= in_switch;
            sync_1 <= sync_0;
        end
    end

    assign hit = sync_1 ^ SWITCH_ACT_LOW;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            db_state <= DB_REL;
            db_cnt   <= '0;
            edge_q   <= 1'b0;
        end else begin
            db_state <= db_next;
            db_cnt   <= db_cnt_next;
            edge_q   <= edge_set;
        end
    end

    always_comb begin
        db_next     = db_state;
        db_cnt_next = db_cnt;
        edge_set    = 1'b0;
        case (db_state)
            DB_REL: begin
                if (hit) begin
                    db_next     = DB_CONF_HI;
                    db_cnt_next = DB_LOAD;
                end
            end
            DB_CONF_HI: begin
                if (!hit) begin
                    db_next = DB_REL;
                end else if (db_cnt == '0) begin
                    db_next  = DB_HELD;
                    edge_set = 1'b1;
                end else begin
                    db_cnt_next = db_cnt - CNT_W'(1);
                end
            end
            DB_HELD: begin
                if (!hit) begin
                    db_next     = DB_CONF_LO;
                    db_cnt_next = DB_LOAD;
                end
            end
            DB_CONF_LO: begin
                if (hit) begin
                    db_next = DB_HELD;
                end else if (db_cnt == '0) begin
                    db_next = DB_REL;
                end else begin
                    db_cnt_next = db_cnt - CNT_W'(1);
                end
            end
            default: db_next = DB_REL;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            game_state <= G_IDLE;
        end else begin
            game_state <= game_next;
        end
    end

    always_comb begin
        game_next = game_state;
        fin_set   = 1'b0;
        if (game_start) begin
            game_next = G_RUN;
        end else if (game_state == G_RUN && !game_active) begin
            game_next = G_DONE;
            fin_set   = 1'b1;
        end
    end

    // A start pulse clears the score, so an edge landing on the same cycle is dropped.
    assign count_en = edge_q && (game_state == G_RUN) && !game_start;
    assign running  = (game_state == G_RUN);

    function automatic logic [15:0] bcd_step(input logic [15:0] cur);
        logic [7:0] s;
        logic [3:0] t;
        logic [3:0] o;
        {s, t, o} = cur;
        if (s < SAT) begin
            s = s + 8'd1;
            if (o == 4'd9) begin
                o = 4'd0;
                t = t + 4'd1;
            end else begin
                o = o + 4'd1;
            end
        end
        return {s, t, o};
    endfunction

    assign step1 = bcd_step({score, score_tens, score_ones});
    assign step2 = bcd_step(step1);

`ifdef STREAK_BONUS_EN
    localparam int                  STREAK_W    = $clog2(STREAK_CYCLES + 1);
    localparam logic [STREAK_W-1:0] STREAK_LOAD = STREAK_W'(STREAK_CYCLES - 1);

    logic                streak_live;
    logic [STREAK_W-1:0] streak_cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            streak_live <= 1'b0;
            streak_cnt  <= '0;
        end else if (game_start) begin
            streak_live <= 1'b0;
            streak_cnt  <= '0;
        end else if (count_en) begin
            streak_live <= 1'b1;
            streak_cnt  <= STREAK_LOAD;
        end else if (streak_live) begin
            if (streak_cnt == '0) begin
                streak_live <= 1'b0;
            end else begin
                streak_cnt <= streak_cnt - STREAK_W'(1);
            end
        end
    end

    assign bonus = streak_live;
`else
    assign bonus = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            score        <= '0;
            score_tens   <= '0;
            score_ones   <= '0;
            basket_pulse <= 1'b0;
            final_valid  <= 1'b0;
        end else begin
            basket_pulse <= count_en;
            final_valid  <= fin_set;
            if (game_start) begin
                score      <= '0;
                score_tens <= '0;
                score_ones <= '0;
            end else if (count_en) begin
                {score, score_tens, score_ones} <= bonus ? step2 : step1;
            end
        end
    end

endmodule

// File: tb/tb_hoop_score_tracker.sv
// Directed bench for hoop_score_tracker with a scoreboard of expected basket/final scores.
module tb_hoop_score_tracker;

    logic       clock = 1'b0;
    logic       reset;
    logic       in_switch;
    logic       game_start;
    logic       game_active;
    logic [7:0] score;
    logic [3:0] score_ones;
    logic [3:0] score_tens;
    logic       basket_pulse;
    logic       running;
    logic       final_valid;

    int total = 0;
    int bad   = 0;
    int exp_q[$];
    int fin_q[$];
    int model = 0;
    bit have_prev = 1'b0;
    int last_period = 0;

    hoop_score_tracker #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W(3),
        .SWITCH_ACT_LOW(1'b1),
        .MAX_SCORE(99),
        .STREAK_CYCLES(20)
    ) dut (
        .clock(clock),
        .reset(reset),
        .in_switch(in_switch),
        .game_start(game_start),
        .game_active(game_active),
        .score(score),
        .score_ones(score_ones),
        .score_tens(score_tens),
        .basket_pulse(basket_pulse),
        .running(running),
        .final_valid(final_valid)
    );

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish, observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check(string tag, logic [15:0] obs, logic [15:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic check_score(string tag);
        check({tag, "_score"}, 16'(score), 16'(model));
        check({tag, "_ones"}, 16'(score_ones), 16'(model % 10));
        check({tag, "_tens"}, 16'(score_tens), 16'(model / 10));
    endtask

    // One ball pass: beam broken (in_switch low) 8 cycles, then clear for lo cycles.
    task automatic pass(int lo, bit counts);
        if (counts) begin
            int add;
            add = 1;
`ifdef STREAK_BONUS_EN
            if (have_prev && last_period < 20) add = 2;
`endif
            model = (model + add > 99) ? 99 : model + add;
            exp_q.push_back(model);
            have_prev   = 1'b1;
            last_period = 8 + lo;
        end
        in_switch = 1'b0;
        tick(8);
        in_switch = 1'b1;
        tick(lo);
    endtask

    task automatic start_game();
        game_start = 1'b1;
        tick();
        game_start = 1'b0;
        model      = 0;
        have_prev  = 1'b0;
    endtask

    task automatic drain(string tag);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || fin_q.size() != 0) && n < 200) begin
            tick();
            n++;
        end
        check({tag, "_pending"}, 16'(exp_q.size() + fin_q.size()), 16'd0);
        exp_q.delete();
        fin_q.delete();
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            if (basket_pulse !== 1'b0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_basket_pulse", 16'(basket_pulse), 16'd0);
                end else begin
                    int p;
                    p = exp_q.pop_front();
                    check("basket_score", 16'(score), 16'(p));
                    check("basket_ones", 16'(score_ones), 16'(p % 10));
                    check("basket_tens", 16'(score_tens), 16'(p / 10));
                end
            end
            if (final_valid !== 1'b0) begin
                if (fin_q.size() == 0) begin
                    check("unexpected_final_valid", 16'(final_valid), 16'd0);
                end else begin
                    int f;
                    f = fin_q.pop_front();
                    check("final_score", 16'(score), 16'(f));
                    check("final_ones", 16'(score_ones), 16'(f % 10));
                    check("final_tens", 16'(score_tens), 16'(f / 10));
                end
            end
        end
    end

    initial begin
        reset       = 1'b1;
        in_switch   = 1'b1;
        game_start  = 1'b0;
        game_active = 1'b0;
        tick(3);
        check("rst_score", 16'(score), 16'd0);
        check("rst_ones", 16'(score_ones), 16'd0);
        check("rst_tens", 16'(score_tens), 16'd0);
        check("rst_basket", 16'(basket_pulse), 16'd0);
        check("rst_running", 16'(running), 16'd0);
        check("rst_final", 16'(final_valid), 16'd0);
        reset = 1'b0;
        tick(2);

        // passes before any game are ignored
        pass(8, 1'b0);
        pass(8, 1'b0);
        drain("idle");
        check_score("idle");
        check("idle_running", 16'(running), 16'd0);

        // bounce: short hit, release, then a solid hit -> one basket
        game_active = 1'b1;
        start_game();
        check("run_running", 16'(running), 16'd1);
        in_switch = 1'b0;
        tick(2);
        in_switch = 1'b1;
        tick(3);
        model = 1;
        exp_q.push_back(model);
        have_prev = 1'b1;
        in_switch = 1'b0;
        tick(10);
        in_switch = 1'b1;
        tick(8);
        drain("bounce");
        check_score("bounce");

        // game flow: 3 passes then time runs out
        start_game();
        pass(8, 1'b1);
        pass(8, 1'b1);
        pass(8, 1'b1);
        fin_q.push_back(model);
        game_active = 1'b0;
        tick(3);
        drain("flow");
        check_score("flow");
        check("flow_running", 16'(running), 16'd0);

        // passes in DONE are ignored
        pass(8, 1'b0);
        pass(8, 1'b0);
        drain("done");
        check_score("done");

        // beam held across game_start never counts
        in_switch = 1'b0;
        tick(12);
        game_active = 1'b1;
        start_game();
        tick(10);
        in_switch = 1'b1;
        tick(10);
        drain("held");
        check_score("held");

        // BCD carry then saturation
        for (int i = 0; i < 10; i++) pass(8, 1'b1);
        drain("carry");
        check_score("carry");
        for (int i = 0; i < 95; i++) pass(8, 1'b1);
        drain("sat");
        check_score("sat");

        // internal edge lands on the game_start cycle: clear wins
        in_switch = 1'b0;
        tick(7);
        game_start = 1'b1;
        tick();
        game_start = 1'b0;
        model      = 0;
        have_prev  = 1'b0;
        tick(4);
        in_switch = 1'b1;
        tick(10);
        drain("race_start");
        check_score("race_start");

        // internal edge lands on the game_active falling cycle: counted and reported
        model = model + 1;
        exp_q.push_back(model);
        fin_q.push_back(model);
        in_switch = 1'b0;
        tick(7);
        game_active = 1'b0;
        tick(3);
        in_switch = 1'b1;
        tick(10);
        drain("race_end");
        check_score("race_end");

        // reset mid-game
        game_active = 1'b1;
        start_game();
        pass(8, 1'b1);
        pass(8, 1'b1);
        drain("pre_reset");
        reset = 1'b1;
        #1;
        check("midrst_score", 16'(score), 16'd0);
        check("midrst_ones", 16'(score_ones), 16'd0);
        check("midrst_tens", 16'(score_tens), 16'd0);
        check("midrst_basket", 16'(basket_pulse), 16'd0);
        check("midrst_running", 16'(running), 16'd0);
        check("midrst_final", 16'(final_valid), 16'd0);
        tick(2);
        reset       = 1'b0;
        game_active = 1'b0;
        model       = 0;
        tick(6);
        check("post_rst_running", 16'(running), 16'd0);
        check_score("post_rst");

`ifdef STREAK_BONUS_EN
        game_active = 1'b1;
        start_game();
        pass(8, 1'b1);
        pass(8, 1'b1);
        drain("streak_close");
        check_score("streak_close");
        start_game();
        pass(30, 1'b1);
        pass(8, 1'b1);
        drain("streak_far");
        check_score("streak_far");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
